// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_cmd_master
//  Purpose  : Turns a simple valid/ready command (address, write data,
//             direction) into one APB3 transfer and returns the result on a
//             valid/ready response channel.
//  Ports    : HCLK, HRESETn           - clock, asynchronous active-low reset
//             req_valid/req_ready     - command handshake
//             req_addr/wdata/write    - command payload
//             rsp_valid/rsp_ready     - response handshake
//             rsp_rdata/rsp_err       - read data (0 on writes and timeouts), error
//             PADDR/PWDATA/PWRITE     - APB address phase signals
//             PSEL/PENABLE            - APB phase control
//             PRDATA/PREADY/PSLVERR   - APB slave returns
//  Options  : APB_CMD_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that
//             sees TIMEOUT_CYCLES consecutive PREADY-low cycles is abandoned
//             and answered with rsp_err=1, rsp_rdata=0.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_master #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]               req_wdata,
   input  logic                      req_write,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [31:0]               rsp_rdata,
   output logic                      rsp_err,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      w_accept;
   logic                      w_capture;
   logic                      w_timeout;
   logic [APB_ADDR_WIDTH-1:0] r_paddr;
   logic [31:0]               r_pwdata;
   logic                      r_pwrite;
   logic [31:0]               r_rsp_rdata;
   logic                      r_rsp_err;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
   localparam int                 c_CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [c_CNT_W-1:0] r_wait_cnt;

   // Held at zero outside ACCESS so every ACCESS phase starts counting from 0.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         r_wait_cnt <= '0;
      else if (r_state != ST_ACCESS)
         r_wait_cnt <= '0;
      else if (!PREADY)
         r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   // Fires on the PREADY-low cycle that brings the count up to TIMEOUT_CYCLES.
   assign w_timeout = (r_state == ST_ACCESS) && !PREADY && (r_wait_cnt == c_TO_LAST);
`else
   // No timeout: wait for PREADY forever. The parameter is referenced only so
   // that both builds share one parameter list; the result is constant 0.
   assign w_timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      // Gated by HRESETn so the command channel stays closed while in reset.
      req_ready   = 1'b0;
      PSEL        = 1'b0;
      PENABLE     = 1'b0;
      rsp_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = HRESETn;
            if (req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            PSEL        = 1'b1;
            w_state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            if (PREADY) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_RESP;
            end else if (w_timeout) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath ---
   // Address-phase signals only change on acceptance, so they stay constant
   // through the transfer and keep their last value between transfers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_pwrite    <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
            r_pwrite <= req_write;
         end
         if (w_capture) begin
            r_rsp_rdata <= r_pwrite ? 32'd0 : PRDATA;
            r_rsp_err   <= PSLVERR;
         end else if (w_timeout) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b1;
         end
      end
   end

   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;
   assign PWRITE    = r_pwrite;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_cmd_master
//  Purpose  : Self-checking bench for apb_cmd_master. Directed vector table,
//             hand-written corner sequences (long stall, reset mid-ACCESS) and
//             randomized transfers checked against a cycle-timeline model.
//  Options  : APB_CMD_MASTER_TIMEOUT_EN - when defined, the DUT is built with
//             TIMEOUT_CYCLES=4 and the model expects timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_master;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
   localparam bit c_TO_EN = 1'b1;
   localparam int c_TO    = 4;
`else
   localparam bit c_TO_EN = 1'b0;
   localparam int c_TO    = 255;
`endif
   localparam int c_AW = 12;

   logic            HCLK;
   logic            HRESETn;
   logic            req_valid;
   logic            req_ready;
   logic [c_AW-1:0] req_addr;
   logic [31:0]     req_wdata;
   logic            req_write;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [31:0]     rsp_rdata;
   logic            rsp_err;
   logic [c_AW-1:0] PADDR;
   logic [31:0]     PWDATA;
   logic            PWRITE;
   logic            PSEL;
   logic            PENABLE;
   logic [31:0]     PRDATA;
   logic            PREADY;
   logic            PSLVERR;

   int r_errors = 0;
   int r_checks = 0;

   apb_cmd_master #(
      .APB_ADDR_WIDTH (c_AW),
      .TIMEOUT_CYCLES (c_TO)
   ) u_dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_write (req_write),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PWRITE    (PWRITE),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      r_checks++;
      if (act !== exp) begin
         r_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference result of one transfer, straight from the rules.
   task automatic model(input bit wr, input int waits, input logic [31:0] prdata,
                        input bit slverr, output logic [31:0] rdata, output bit err,
                        output int acc);
      if (c_TO_EN && waits >= c_TO) begin
         acc   = c_TO;
         rdata = 32'd0;
         err   = 1'b1;
      end else begin
         acc   = waits + 1;
         rdata = wr ? 32'd0 : prdata;
         err   = slverr;
      end
   endtask

   // Entered at a negedge with the DUT idle; returns at the negedge of the
   // first idle cycle after the response is consumed. Cycle k=1 is the cycle
   // after acceptance.
   task automatic xfer(input bit wr, input logic [c_AW-1:0] addr, input logic [31:0] wdata,
                       input int waits, input logic [31:0] prdata, input bit slverr,
                       input int stall, input logic [31:0] exp_rdata, input bit exp_err);
      int  acc;
      logic [31:0] m_rdata;
      bit  m_err;
      model(wr, waits, prdata, slverr, m_rdata, m_err, acc);
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      rsp_ready = 1'($urandom);
      @(negedge HCLK);
      for (int k = 1; k <= 2 + acc + stall; k++) begin
         bit in_acc, in_rsp;
         in_acc = (k >= 2) && (k <= 1 + acc);
         in_rsp = (k >= 2 + acc);
         chk("psel",     64'(PSEL),      64'(k <= 1 + acc));
         chk("penable",  64'(PENABLE),   64'(in_acc));
         chk("rsp_valid",64'(rsp_valid), 64'(in_rsp));
         chk("req_ready_busy", 64'(req_ready), 64'd0);
         chk("paddr",    64'(PADDR),     64'(addr));
         chk("pwrite",   64'(PWRITE),    64'(wr));
         chk("pwdata",   64'(PWDATA),    64'(wdata));
         if (in_rsp) begin
            chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
            chk("rsp_err",   64'(rsp_err),   64'(exp_err));
            chk("model_rdata", 64'(m_rdata), 64'(exp_rdata));
         end
         // Commands offered while busy must be ignored.
         req_valid = 1'($urandom);
         req_write = 1'($urandom);
         req_addr  = c_AW'($urandom);
         req_wdata = $urandom;
         if (in_acc && (k - 2 == waits)) begin
            PREADY  = 1'b1;
            PRDATA  = prdata;
            PSLVERR = slverr;
         end else if (in_acc) begin
            PREADY  = 1'b0;
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
         end else begin
            PREADY  = 1'($urandom);
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
         end
         rsp_ready = in_rsp ? (k == 2 + acc + stall) : 1'($urandom);
         @(negedge HCLK);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("rsp_valid_after", 64'(rsp_valid), 64'd0);
   endtask

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      bit          slverr;
      int          stall;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [31:0] e_rdata;
      bit          e_err;
      int          e_acc;
      vecs[0] = '{1'b1, 12'h008, 32'h0000_00FF, 0, 32'hDEAD_BEEF, 1'b0, 0, 32'h0000_0000, 1'b0};
      vecs[1] = '{1'b0, 12'h004, 32'h1111_2222, 2, 32'hA5A5_0F0F, 1'b0, 0, 32'hA5A5_0F0F, 1'b0};
      vecs[2] = '{1'b0, 12'h018, 32'h0,         0, 32'h1234_5678, 1'b1, 3, 32'h1234_5678, 1'b1};
      vecs[3] = '{1'b1, 12'hFFF, 32'hFFFF_FFFF, 1, 32'hCAFE_F00D, 1'b1, 1, 32'h0000_0000, 1'b1};
      vecs[4] = '{1'b0, 12'h000, 32'h0,         3, 32'h0000_0000, 1'b0, 2, 32'h0000_0000, 1'b0};

      HRESETn   = 1'b0;
      req_valid = 1'b1;
      req_addr  = 12'hABC;
      req_wdata = 32'h5555_AAAA;
      req_write = 1'b1;
      rsp_ready = 1'b0;
      PRDATA    = 32'hFFFF_FFFF;
      PREADY    = 1'b1;
      PSLVERR   = 1'b1;
      repeat (3) @(negedge HCLK);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_psel",      64'(PSEL),      64'd0);
      chk("rst_penable",   64'(PENABLE),   64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_outputs",   64'({PADDR, PWDATA, PWRITE, rsp_rdata, rsp_err}), 64'd0);
      req_valid = 1'b0;
      HRESETn   = 1'b1;
      @(negedge HCLK);

      for (int i = 0; i < 5; i++)
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].prdata,
              vecs[i].slverr, vecs[i].stall, vecs[i].exp_rdata, vecs[i].exp_err);

      // Slave stuck for 55 cycles: held without timeout, abandoned with it.
      model(1'b0, 55, 32'h7777_8888, 1'b0, e_rdata, e_err, e_acc);
      xfer(1'b0, 12'h010, 32'h0, 55, 32'h7777_8888, 1'b0, 1, e_rdata, e_err);

      // Reset pulsed in the middle of ACCESS: transfer is dropped silently.
      chk("pre_rst_ready", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 12'h020;
      @(negedge HCLK);
      req_valid = 1'b0;
      PREADY    = 1'b0;
      repeat (2) @(negedge HCLK);
      chk("pre_rst_penable", 64'(PENABLE), 64'd1);
      #2 HRESETn = 1'b0;
      #1;
      chk("async_psel",      64'(PSEL),      64'd0);
      chk("async_penable",   64'(PENABLE),   64'd0);
      chk("async_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("async_paddr",     64'(PADDR),     64'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      xfer(1'b0, 12'h020, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 0, 32'h0BAD_F00D, 1'b0);

      // Randomized transfers against the model.
      for (int i = 0; i < 25; i++) begin
         bit          r_wr;
         logic [11:0] r_addr;
         logic [31:0] r_wdata, r_prdata;
         int          r_waits, r_stall;
         bit          r_slv;
         r_wr     = 1'($urandom);
         r_addr   = 12'($urandom);
         r_wdata  = $urandom;
         r_prdata = $urandom;
         r_waits  = $urandom_range(0, 5);
         r_stall  = $urandom_range(0, 2);
         r_slv    = 1'($urandom);
         model(r_wr, r_waits, r_prdata, r_slv, e_rdata, e_err, e_acc);
         xfer(r_wr, r_addr, r_wdata, r_waits, r_prdata, r_slv, r_stall, e_rdata, e_err);
      end

      $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, meaning PADDR/req_addr width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of ACCESS wait cycles, effective only with APB_CMD_MASTER_TIMEOUT_EN.
REQ-003 SHALL have the following ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when high with req_valid.
- req_addr  in  APB_ADDR_WIDTH  command address.
- req_wdata  in  32  write data.
- req_write  in  1  1=write, 0=read.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR or timeout.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Function
REQ-004 SHALL implement an FSM with the states IDLE, SETUP, ACCESS and RESP.
REQ-005 SHALL drive req_ready=1 only in IDLE; req_valid&&req_ready SHALL latch req_addr, req_wdata and req_write into PADDR, PWDATA and PWRITE, with the next state SETUP.
REQ-006 SHALL drive PSEL=1 and PENABLE=0 in SETUP for exactly one cycle, then go unconditionally to ACCESS.
REQ-007 SHALL drive PSEL=1 and PENABLE=1 in ACCESS and remain in ACCESS while PREADY=0.
REQ-008 SHALL, in ACCESS with PREADY=1, perform the following, with the next state RESP:
- capture PRDATA into rsp_rdata if PWRITE=0, else load 0;
- capture PSLVERR into rsp_err.
REQ-009 SHALL, in RESP, drive rsp_valid=1, PSEL=0 and PENABLE=0, and hold rsp_rdata and rsp_err stable until rsp_ready=1, then go to IDLE.
REQ-010 SHALL hold PADDR, PWDATA and PWRITE constant from SETUP through ACCESS completion and keep their last values outside transfers.
REQ-011 SHALL, with a zero-wait slave, assert PSEL in cycle N+1 (SETUP), assert PENABLE in N+2 (ACCESS) and assert rsp_valid in N+3, where N is the acceptance cycle; each PREADY-low cycle SHALL add one cycle.
REQ-012 SHALL leave at least one IDLE cycle between consecutive transfers; PENABLE SHALL never be asserted without PSEL.
REQ-013 SHALL ignore PRDATA, PREADY and PSLVERR outside ACCESS.
REQ-014 SHALL ignore req_valid outside IDLE; a command SHALL NOT be dropped while it is held.

Reset
REQ-015 SHALL, while HRESETn=0 (asynchronously), force the FSM to IDLE and clear the following outputs:
- req_ready=0 during reset, 1 after release;
- rsp_valid=0, rsp_rdata=0, rsp_err=0;
- PADDR=0, PWDATA=0, PWRITE=0, PSEL=0, PENABLE=0;
- timeout counter=0.
REQ-016 SHALL abandon a transfer on reset mid-SETUP or mid-ACCESS, with no response produced.

Configuration
REQ-017 SHALL, when APB_CMD_MASTER_TIMEOUT_EN is defined, count consecutive PREADY=0 ACCESS cycles from 0.
- When the count reaches TIMEOUT_CYCLES, the FSM SHALL drop PSEL and PENABLE and go to RESP with rsp_err=1 and rsp_rdata=0.
- The counter SHALL clear on entry to ACCESS.
REQ-018 SHALL, when APB_CMD_MASTER_TIMEOUT_EN is undefined, have no counter, wait for PREADY indefinitely and leave TIMEOUT_CYCLES unused.

Verification
REQ-019 SHALL cover: write 0x000000FF to 0x008, PREADY=1 -> PSEL in N+1, PENABLE in N+2 with PWRITE=1, rsp_valid in N+3, rsp_err=0, rsp_rdata=0.
REQ-020 SHALL cover: read 0x004 with PREADY low for 2 ACCESS cycles, PRDATA=0xA5A5_0F0F -> rsp_valid in N+5, rsp_rdata=0xA5A5_0F0F, PADDR stable throughout.
REQ-021 SHALL cover: read 0x018 with PSLVERR=1 at PREADY -> rsp_err=1; rsp_valid held 3 cycles with rsp_ready=0 and values unchanged; then IDLE.
REQ-022 SHALL cover: TIMEOUT_EN defined, TIMEOUT_CYCLES=4, PREADY stuck 0 -> PSEL drops after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0; undefined -> PSEL held 50+ cycles.
REQ-023 SHALL cover: HRESETn pulsed low during ACCESS -> PSEL=0, PENABLE=0, rsp_valid=0 immediately; next command completes normally.
